// File: rtl/uart_pkg.sv
// Shared UART constants and the autobaud controller state encoding.
package uart_pkg;

   localparam int DVSR_W = 11;
   localparam int CNT_W  = 18;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_GUARD      = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_MEASURE    = 3'd3,
      ST_CALC       = 3'd4
   } autobaud_state_t;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the raw RX pin plus a registered falling-edge pulse.
// The flops reset to the idle-high line level so reset release never fakes a fall.
module rx_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_sync,
   output logic fall
);

   logic meta_r;
   logic sync_r;
   logic sync_d_r;
   logic fall_r;

   // Synchronize rx and flag a 1->0 transition of the synchronized level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r   <= 1'b1;
         sync_r   <= 1'b1;
         sync_d_r <= 1'b1;
         fall_r   <= 1'b0;
      end else begin
         meta_r   <= rx;
         sync_r   <= meta_r;
         sync_d_r <= sync_r;
         fall_r   <= sync_d_r & ~sync_r;
      end
   end

   assign rx_sync = sync_r;
   assign fall    = fall_r;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Owns the baud tick divisor: measures a 0x55 sync character, range-checks the
// resulting divisor and drives it; a host write can load the divisor directly.
module uart_autobaud_ctrl #(
   parameter int DVSR_W       = uart_pkg::DVSR_W,
   parameter int CNT_W        = uart_pkg::CNT_W,
   parameter int DEFAULT_DVSR = 650,
   parameter int MIN_DVSR     = 3,
   parameter int GUARD_CYC    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   input  logic              start_auto,
   input  logic              cpu_wr,
   input  logic [DVSR_W-1:0] cpu_dvsr,
   output logic [DVSR_W-1:0] dvsr,
   output logic              busy,
   output logic              locked,
   output logic              err
);

   import uart_pkg::*;

   localparam int                GCNT_W     = $clog2(GUARD_CYC + 1);
   localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]    Q_MIN      = (CNT_W+1)'(MIN_DVSR + 1);
   localparam logic [CNT_W:0]    Q_MAX      = (CNT_W+1)'(2**DVSR_W);
   localparam logic [DVSR_W-1:0] DVSR_RST   = DVSR_W'(DEFAULT_DVSR);

   autobaud_state_t   state_r;
   logic [GCNT_W-1:0] guard_cnt_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  last_r;
   logic [CNT_W-1:0]  t1_r;
   logic [CNT_W-1:0]  total_r;
   logic [1:0]        edge_idx_r;
   logic [DVSR_W-1:0] dvsr_r;
   logic              busy_r;
   logic              locked_r;
   logic              err_r;

   logic              rx_sync_s;
   logic              fall_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic [CNT_W-1:0]  intv_s;
   logic [CNT_W-1:0]  lo_s;
   logic [CNT_W:0]    hi_s;
   logic              in_win_s;
   logic              timeout_s;
   logic [CNT_W:0]    q_s;
   logic              q_ok_s;
   logic [DVSR_W-1:0] dvsr_calc_s;

   rx_sync_edge u_rx_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_sync (rx_sync_s),
      .fall    (fall_s)
   );

   // Interval since the previous fall, +/-25% window around T1, rounded quotient.
   always_comb begin
      cnt_inc_s   = cnt_r + CNT_W'(1'b1);
      intv_s      = cnt_inc_s - last_r;
      lo_s        = t1_r - (t1_r >> 2'd2);
      hi_s        = {1'b0, t1_r} + {3'b000, t1_r[CNT_W-1:2]};
      in_win_s    = (intv_s >= lo_s) && ({1'b0, intv_s} <= hi_s);
      timeout_s   = (cnt_inc_s == CNT_MAX);
      q_s         = ({1'b0, total_r} + (CNT_W+1)'(7'd64)) >> 3'd7;
      q_ok_s      = (q_s >= Q_MIN) && (q_s <= Q_MAX);
      dvsr_calc_s = q_s[DVSR_W-1:0] - DVSR_W'(1'b1);
   end

   // Measurement FSM with registered divisor and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         guard_cnt_r <= '0;
         cnt_r       <= '0;
         last_r      <= '0;
         t1_r        <= '0;
         total_r     <= '0;
         edge_idx_r  <= 2'd0;
         dvsr_r      <= DVSR_RST;
         busy_r      <= 1'b0;
         locked_r    <= 1'b0;
         err_r       <= 1'b0;
      end else if (cpu_wr) begin
         dvsr_r   <= cpu_dvsr;
         state_r  <= ST_IDLE;
         busy_r   <= 1'b0;
         locked_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_auto) begin
                  state_r     <= ST_GUARD;
                  busy_r      <= 1'b1;
                  locked_r    <= 1'b0;
                  err_r       <= 1'b0;
                  guard_cnt_r <= '0;
                  cnt_r       <= '0;
               end
            end
            // cnt already runs here so a line stuck low still times out.
            ST_GUARD: begin
               cnt_r <= cnt_inc_s;
               if (timeout_s) begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (!rx_sync_s) begin
                  guard_cnt_r <= '0;
               end else if (guard_cnt_r == GUARD_LAST) begin
                  state_r <= ST_WAIT_START;
               end else begin
                  guard_cnt_r <= guard_cnt_r + GCNT_W'(1'b1);
               end
            end
            ST_WAIT_START: begin
               if (fall_s) begin
                  cnt_r      <= '0;
                  last_r     <= '0;
                  edge_idx_r <= 2'd0;
                  state_r    <= ST_MEASURE;
               end else if (timeout_s) begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_MEASURE: begin
               if (fall_s) begin
                  if ((edge_idx_r != 2'd0) && !in_win_s) begin
                     err_r   <= 1'b1;
                     busy_r  <= 1'b0;
                     state_r <= ST_IDLE;
                  end else if (edge_idx_r == 2'd3) begin
                     total_r <= cnt_inc_s;
                     state_r <= ST_CALC;
                  end else begin
                     if (edge_idx_r == 2'd0) begin
                        t1_r <= cnt_inc_s;
                     end
                     last_r     <= cnt_inc_s;
                     cnt_r      <= cnt_inc_s;
                     edge_idx_r <= edge_idx_r + 2'd1;
                  end
               end else if (timeout_s) begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_CALC: begin
               if (q_ok_s) begin
                  dvsr_r   <= dvsr_calc_s;
                  locked_r <= 1'b1;
               end else begin
                  err_r <= 1'b1;
               end
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign dvsr   = dvsr_r;
   assign busy   = busy_r;
   assign locked = locked_r;
   assign err    = err_r;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: directed and randomized sync frames
// compared against a fall-time based reference model.
module tb_uart_autobaud_ctrl;

   localparam int DVSR_W       = 6;
   localparam int CNT_W        = 14;
   localparam int DEFAULT_DVSR = 40;
   localparam int MIN_DVSR     = 3;
   localparam int GUARD_CYC    = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx;
   logic              start_auto;
   logic              cpu_wr;
   logic [DVSR_W-1:0] cpu_dvsr;
   logic [DVSR_W-1:0] dvsr;
   logic              busy;
   logic              locked;
   logic              err;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_dvsr;

   always #5 clk = ~clk;

   uart_autobaud_ctrl #(
      .DVSR_W       (DVSR_W),
      .CNT_W        (CNT_W),
      .DEFAULT_DVSR (DEFAULT_DVSR),
      .MIN_DVSR     (MIN_DVSR),
      .GUARD_CYC    (GUARD_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .start_auto (start_auto),
      .cpu_wr     (cpu_wr),
      .cpu_dvsr   (cpu_dvsr),
      .dvsr       (dvsr),
      .busy       (busy),
      .locked     (locked),
      .err        (err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_auto = 1'b1;
      step(1);
      start_auto = 1'b0;
   endtask

   task automatic pulse_cpu(input int val);
      cpu_dvsr = DVSR_W'(val);
      cpu_wr   = 1'b1;
      step(1);
      cpu_wr   = 1'b0;
   endtask

   task automatic drive_bits(input logic [9:0] lv, input int dur[10], input int lo, input int hi);
      for (int k = lo; k < hi; k++) begin
         rx = lv[k];
         step(dur[k]);
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      for (int i = 0; i < bound && busy; i++) @(negedge clk);
      @(negedge clk);
      check(tag, busy, 1'b0);
   endtask

   // Reference: find fall times in the frame, apply the interval/rounding rules.
   function automatic void predict(input logic [9:0] lv, input int dur[10],
                                   output bit lk, output int nd);
      int   falls[$];
      int   t;
      logic prev;
      int   t1, lo, hi, d, total, q;
      t = 0; prev = 1'b1; lk = 1'b0; nd = exp_dvsr;
      for (int k = 0; k < 10; k++) begin
         if (prev && !lv[k]) falls.push_back(t);
         prev = lv[k];
         t += dur[k];
      end
      if (falls.size() < 2) return;
      t1 = falls[1] - falls[0];
      lo = t1 - t1 / 4;
      hi = t1 + t1 / 4;
      for (int k = 2; k < 5; k++) begin
         if (k >= falls.size()) return;
         d = falls[k] - falls[k-1];
         if (d < lo || d > hi) return;
      end
      total = falls[4] - falls[0];
      q = (total + 64) / 128;
      if (q >= MIN_DVSR + 1 && q <= 2**DVSR_W) begin
         lk = 1'b1;
         nd = q - 1;
      end
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] b, input int per, input int jit);
      int         dur[10];
      logic [9:0] lv;
      bit         lk;
      int         nd;
      lv = {1'b1, b, 1'b0};
      for (int k = 0; k < 9; k++) dur[k] = per + int'($urandom_range(0, 2 * jit)) - jit;
      dur[9] = 60;
      predict(lv, dur, lk, nd);
      pulse_start();
      @(negedge clk);
      check({tag, "_busy_on"}, busy, 1'b1);
      check({tag, "_locked_clr"}, locked, 1'b0);
      step(1);
      rx = 1'b1;
      step(GUARD_CYC + 20);
      drive_bits(lv, dur, 0, 5);
      @(negedge clk);
      check({tag, "_dvsr_mid"}, dvsr, exp_dvsr);
      step(1);
      drive_bits(lv, dur, 5, 10);
      wait_idle({tag, "_busy_off"}, 200);
      check({tag, "_locked"}, locked, lk);
      check({tag, "_err"}, err, !lk);
      check({tag, "_dvsr"}, dvsr, nd);
      exp_dvsr = nd;
      step(1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int per;
      int dur[10];
      rst = 1'b1; rx = 1'b1; start_auto = 1'b0; cpu_wr = 1'b0; cpu_dvsr = '0;
      exp_dvsr = DEFAULT_DVSR;
      step(4);
      rst = 1'b0;
      step(2);
      @(negedge clk);
      check("rst_dvsr", dvsr, DEFAULT_DVSR);
      check("rst_busy", busy, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_err", err, 1'b0);
      step(1);

      cpu_dvsr = 6'd53;
      cpu_wr   = 1'b1;
      @(negedge clk);
      check("cpu_before_edge", dvsr, DEFAULT_DVSR);
      step(1);
      cpu_wr = 1'b0;
      @(negedge clk);
      check("cpu_dvsr53", dvsr, 53);
      exp_dvsr = 53;
      step(1);

      run_frame("top_1024", 8'h55, 1024, 0);
      run_frame("baud_864", 8'h55, 864, 0);
      run_frame("bad_57", 8'h57, 864, 0);
      run_frame("over_1040", 8'h55, 1040, 0);
      run_frame("min_64", 8'h55, 64, 0);
      run_frame("under_48", 8'h55, 48, 0);
      for (int i = 0; i < 4; i++) begin
         per = int'($urandom_range(40, 300));
         run_frame($sformatf("rnd%0d", i), 8'h55, per, int'($urandom_range(0, per / 6)));
      end

      // A single fall with nothing after it must time out.
      pulse_start();
      rx = 1'b1;
      step(GUARD_CYC + 20);
      rx = 1'b0;
      step(100);
      rx = 1'b1;
      step(16100);
      @(negedge clk);
      check("tmo_still_busy", busy, 1'b1);
      step(1);
      wait_idle("tmo_busy_off", 400);
      check("tmo_err", err, 1'b1);
      check("tmo_locked", locked, 1'b0);
      check("tmo_dvsr", dvsr, exp_dvsr);
      step(1);

      cpu_dvsr   = 6'd21;
      cpu_wr     = 1'b1;
      start_auto = 1'b1;
      step(1);
      cpu_wr     = 1'b0;
      start_auto = 1'b0;
      @(negedge clk);
      check("prio_dvsr", dvsr, 21);
      check("prio_busy", busy, 1'b0);
      exp_dvsr = 21;
      step(1);

      for (int k = 0; k < 9; k++) dur[k] = 200;
      dur[9] = 60;
      pulse_start();
      rx = 1'b1;
      step(GUARD_CYC + 20);
      drive_bits({1'b1, 8'h55, 1'b0}, dur, 0, 4);
      pulse_cpu(37);
      @(negedge clk);
      check("abort_dvsr", dvsr, 37);
      check("abort_busy", busy, 1'b0);
      check("abort_locked", locked, 1'b0);
      check("abort_err", err, 1'b0);
      step(1);
      rx = 1'b1;
      step(60);
      drive_bits({1'b1, 8'h55, 1'b0}, dur, 0, 10);
      step(20);
      @(negedge clk);
      check("noarm_dvsr", dvsr, 37);
      check("noarm_locked", locked, 1'b0);
      check("noarm_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_autobaud_ctrl.md
# uart_autobaud_ctrl

Configuration controller for the UART baud tick generator: owns the 11-bit divisor that sets the 16x oversampling tick period (tick period = dvsr+1 clocks). It measures a 0x55 sync character on the receive line, computes and range-checks the matching divisor, and drives it to the tick generator. A host path can also load the divisor directly. Sits between the RX pin synchronizer and the baud tick generator, alongside the UART RX/TX datapath.

## Interface
- DVSR_W, 11: divisor width; must match the tick generator.
- CNT_W, 18: measurement counter width (covers 128·2^DVSR_W).
- DEFAULT_DVSR, 650: divisor after reset (100 MHz, 9600 baud).
- MIN_DVSR, 3: smallest divisor accepted from measurement.
- GUARD_CYC, 1024: consecutive rx-high clocks required before arming.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  raw UART receive line, asynchronous to clk.
- start_auto  in  1  one-cycle pulse: begin autobaud measurement.
- cpu_wr  in  1  one-cycle pulse: load cpu_dvsr.
- cpu_dvsr  in  DVSR_W  host divisor value.
- dvsr  out  DVSR_W  divisor to the tick generator; registered.
- busy  out  1  high while a measurement is in progress.
- locked  out  1  high after a successful measurement, until next start_auto/cpu_wr.
- err  out  1  sticky error of the last measurement; cleared by start_auto/cpu_wr.

## Operation
- rx passes through a 2-FF synchronizer; fall = one-cycle pulse on synchronized 1→0.
- FSM: IDLE, GUARD, WAIT_START, MEASURE, CALC.
- IDLE: start_auto → GUARD; busy=1; locked and err cleared.
- GUARD: count consecutive rx-high clocks; rx low resets the count; reaching GUARD_CYC → WAIT_START.
- WAIT_START: on fall, clear cnt and edge index → MEASURE.
- MEASURE: cnt increments every clock. On each fall, record the interval since the previous fall. 0x55 (LSB first) gives falls at bit positions 0, 2, 4, 6, 8. Interval 1 is stored as T1. Intervals 2–4 must lie within [T1 − T1/4, T1 + T1/4] (integer shifts); otherwise err=1 → IDLE. On the 4th fall after start → CALC with total = cnt.
- Timeout: cnt reaching 2^CNT_W−1 sets err=1 → IDLE. dvsr is unchanged.
- CALC: q = (total + 64) >> 7 (round to nearest). Cases:
  - MIN_DVSR+1 ≤ q ≤ 2^DVSR_W: dvsr = q−1; locked=1.
  - Otherwise: err=1; dvsr unchanged.
  - Either case → IDLE.
- cpu_wr in any state: dvsr=cpu_dvsr; abort to IDLE; locked=0; err=0; busy=0. Takes priority over start_auto in the same cycle.
- start_auto while busy is ignored.

## Timing
- Reset values: dvsr=DEFAULT_DVSR, busy=0, locked=0, err=0, state IDLE, counters 0.
- cpu_wr: dvsr updates on the next clock edge.
- rx to fall latency: 3 clocks. This is identical for all edges, so intervals are unaffected.
- total = clocks from the start fall pulse to the 4th subsequent fall pulse.
- dvsr, locked, and err update 1 clock after CALC entry. busy deasserts on the same edge.
- dvsr only changes in CALC or on cpu_wr; it is never glitched mid-measurement.
- rst mid-measurement: immediate return to reset values.

## Structure
- Package uart_pkg: DVSR_W, CNT_W constants; autobaud_state_t enum.
- Sub-module rx_sync_edge: 2-FF synchronizer plus falling-edge pulse; reused by UART RX.

## Test plan
- Reset → dvsr=650, busy=0, locked=0, err=0. Then cpu_wr with cpu_dvsr=53 → dvsr=53 next clock.
- start_auto; rx idle 2000 clocks; 0x55 at 10416 clocks/bit → dvsr=650, locked=1, err=0, busy falls.
- Same at 864 clocks/bit (115200 baud) → dvsr=53, locked=1.
- Send 0x57 at 864 clocks/bit → interval check fails → err=1, dvsr unchanged, locked=0.
- start_auto, then rx held low indefinitely or no further falls → timeout after 2^18−1 clocks → err=1, busy=0.
- cpu_wr with 100 mid-MEASURE → dvsr=100, busy=0. A later 0x55 causes no update until a new start_auto.
